// File: rtl/key_debounce_bank.sv
// key_debounce_bank
// Conditions N raw push-button / switch pins for the table-tennis board.
// Each pin is synchronised, normalised so that 1 means "pressed", and
// sampled on a shared scan tick. A new level is accepted only after it has
// been seen on STABLE_CNT consecutive scan samples. Each accepted change
// produces a one-clk press or release pulse.
//
// Optional feature macro: KEY_REPEAT_EN
//   defined   -> per-key hold counters generate auto-repeat pulses
//   undefined -> no hold counters; key_repeat is tied to 0
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   keys_in      raw asynchronous key pins (N_KEYS)
//   scan_tick    one-clk pulse at every scan sample instant
//   key_state    debounced level per key, 1 = pressed
//   key_press    one-clk pulse when key_state goes 0->1
//   key_release  one-clk pulse when key_state goes 1->0
//   key_repeat   one-clk auto-repeat pulse while a key is held

module key_debounce_bank #(
    parameter int N_KEYS     = 4,
    parameter int SCAN_DIV   = 1_000_000,
    parameter int STABLE_CNT = 2,
    parameter int ACTIVE_LOW = 0,
    parameter int REPEAT_DLY = 25,
    parameter int REPEAT_PER = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] keys_in,
    output logic              scan_tick,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(STABLE_CNT + 1);

    localparam logic [PW-1:0]     PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(STABLE_CNT - 1);
    // Pin level of a released key; used both as the synchroniser reset value
    // and as the XOR mask that turns an active-low pin into "1 = pressed".
    localparam logic [N_KEYS-1:0] RELEASED_PIN = {N_KEYS{ACTIVE_LOW != 0}};

    // Catch illegal configurations at elaboration time.
    if (SCAN_DIV < 2 || STABLE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_params
        $error("key_debounce_bank: illegal parameter combination");
    end

    logic [N_KEYS-1:0] sync_meta;
    logic [N_KEYS-1:0] sync_out;
    logic [N_KEYS-1:0] sample;
    logic [PW-1:0]     prescale;

    logic [CW-1:0]     agree_cnt [N_KEYS];
    logic [CW-1:0]     agree_nxt [N_KEYS];
    logic [N_KEYS-1:0] state_nxt;
    logic [N_KEYS-1:0] press_nxt;
    logic [N_KEYS-1:0] release_nxt;

    // Two-flop synchroniser; resets to the released pin level so that the
    // first samples after reset never look like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= RELEASED_PIN;
            sync_out  <= RELEASED_PIN;
        end else begin
            sync_meta <= keys_in;
            sync_out  <= sync_meta;
        end
    end

    assign sample = sync_out ^ RELEASED_PIN;

    // Scan prescaler; scan_tick is registered so it rises the cycle after
    // the count reaches its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale  <= '0;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= (prescale == PRE_LAST);
            if (prescale == PRE_LAST) begin
                prescale <= '0;
            end else begin
                prescale <= prescale + PW'(1);
            end
        end
    end

    // Agreement debouncer: a sample differing from the accepted level bumps
    // the counter; the STABLE_CNT-th consecutive differing sample accepts it.
    // Any agreeing sample in between throws the partial count away.
    always_comb begin
        state_nxt   = key_state;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            agree_nxt[i] = agree_cnt[i];
        end
        if (scan_tick) begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (sample[i] == key_state[i]) begin
                    agree_nxt[i] = '0;
                end else if (agree_cnt[i] == CNT_LAST) begin
                    agree_nxt[i]   = '0;
                    state_nxt[i]   = sample[i];
                    press_nxt[i]   = sample[i];
                    release_nxt[i] = ~sample[i];
                end else begin
                    agree_nxt[i] = agree_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Debounce state; pulse outputs are recomputed every cycle so they can
    // only ever be one clk wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                agree_cnt[i] <= '0;
            end
        end else begin
            key_state   <= state_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            for (int i = 0; i < N_KEYS; i++) begin
                agree_cnt[i] <= agree_nxt[i];
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW      = $clog2(REP_MAX + 1);

    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER);

    logic [RW-1:0]     hold_cnt [N_KEYS];
    logic [RW-1:0]     hold_nxt [N_KEYS];
    logic [RW-1:0]     hold_inc;
    logic [N_KEYS-1:0] rep_phase;
    logic [N_KEYS-1:0] phase_nxt;
    logic [N_KEYS-1:0] repeat_nxt;

    // Hold counter: counts ticks while the key stays pressed. rep_phase
    // selects the limit: the initial delay before the first repeat, then the
    // shorter repeat period. The press tick itself is not counted because
    // key_state is still 0 while that tick is processed.
    always_comb begin
        phase_nxt  = rep_phase;
        repeat_nxt = '0;
        hold_inc   = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            hold_nxt[i] = hold_cnt[i];
        end
        if (scan_tick) begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (!key_state[i] || release_nxt[i]) begin
                    hold_nxt[i]  = '0;
                    phase_nxt[i] = 1'b0;
                end else begin
                    hold_inc = hold_cnt[i] + RW'(1);
                    if ((!rep_phase[i] && hold_inc == DLY_LAST) ||
                        (rep_phase[i] && hold_inc == PER_LAST)) begin
                        repeat_nxt[i] = 1'b1;
                        hold_nxt[i]   = '0;
                        phase_nxt[i]  = 1'b1;
                    end else begin
                        hold_nxt[i] = hold_inc;
                    end
                end
            end
        end
    end

    // Hold counter registers and the aligned repeat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_phase  <= '0;
            key_repeat <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            rep_phase  <= phase_nxt;
            key_repeat <= repeat_nxt;
            for (int i = 0; i < N_KEYS; i++) begin
                hold_cnt[i] <= hold_nxt[i];
            end
        end
    end
`else
    assign key_repeat = '0;
`endif

endmodule

// File: tb/tb_key_debounce_bank.sv
// tb_key_debounce_bank
// Scoreboard bench for key_debounce_bank (4 keys, scan every 4 clks,
// 3-sample debounce, repeat after 4 ticks then every 2). Stimulus pushes the
// expected pulse events, tagged with the scan tick count at which they must
// appear; a monitor pops and compares whenever the DUT emits a pulse.

module tb_key_debounce_bank;

    localparam int STABLE = 3;

    typedef struct {
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rep;
        logic [3:0] state;
        int         tag;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] keys_in;
    logic       scan_tick;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_repeat;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         tick_no  = 0;
    logic [3:0] rep_mask = 4'hF;

    key_debounce_bank #(
        .N_KEYS(4), .SCAN_DIV(4), .STABLE_CNT(STABLE), .ACTIVE_LOW(0),
        .REPEAT_DLY(4), .REPEAT_PER(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys_in(keys_in), .scan_tick(scan_tick),
        .key_state(key_state), .key_press(key_press), .key_release(key_release),
        .key_repeat(key_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of scan ticks whose processing edge has already passed.
    always @(posedge clk) begin
        if (scan_tick) tick_no <= tick_no + 1;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] press, input logic [3:0] rel,
                            input logic [3:0] rep, input logic [3:0] state, input int tag);
        exp_t e;
        e.press = press; e.rel = rel; e.rep = rep; e.state = state; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Drive new key levels at a tick negedge; a change accepted by the DUT
    // shows up STABLE+1 ticks later (the current tick still sees old data).
    task automatic apply_stimulus(input logic [3:0] keys, input logic [3:0] press,
                                  input logic [3:0] rel, input logic [3:0] state);
        keys_in = keys;
        if ((press | rel) != 4'h0) push_exp(press, rel, 4'h0, state, tick_no + STABLE + 1);
    endtask

    // Wait until the negedge where scan_tick is high and tick_no == n.
    task automatic wait_until_tick(input int n);
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(scan_tick && tick_no == n) && budget < 2000);
        if (budget >= 2000) check_output("tick_timeout", 32'(tick_no), 32'(n));
    endtask

    task automatic measure_period();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_tick && n < 100);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_tick && n < 100);
        check_output("scan_period", 32'(n), 32'd4);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if ((key_press | key_release | (key_repeat & rep_mask)) != 4'h0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse: press=%b release=%b repeat=%b tick=%0d, none expected",
                             key_press, key_release, key_repeat, tick_no);
                end else begin
                    e = exp_q.pop_front();
                    check_output("pulse_press",   32'(key_press), 32'(e.press));
                    check_output("pulse_release", 32'(key_release), 32'(e.rel));
                    check_output("pulse_repeat",  32'(key_repeat & rep_mask), 32'(e.rep & rep_mask));
                    check_output("pulse_state",   32'(key_state), 32'(e.state));
                    check_output("pulse_tick",    32'(tick_no), 32'(e.tag));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int p;
        rst_n   = 1'b0;
        keys_in = 4'hF;
        repeat (3) @(negedge clk);
        check_output("reset_scan_tick", 32'(scan_tick), 32'd0);
        check_output("reset_state",     32'(key_state), 32'd0);
        check_output("reset_press",     32'(key_press), 32'd0);
        check_output("reset_release",   32'(key_release), 32'd0);
        check_output("reset_repeat",    32'(key_repeat), 32'd0);
        keys_in = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        measure_period();
        measure_period();

        // Clean press on key 0.
        t = tick_no;
        apply_stimulus(4'b0001, 4'b0001, 4'b0000, 4'b0001);
        wait_until_tick(t + 7);
        check_output("press_state", 32'(key_state), 32'b0001);

        // Two-sample glitch on key 1 must be ignored.
        t = tick_no;
        apply_stimulus(4'b0011, 4'b0000, 4'b0000, 4'b0000);
        wait_until_tick(t + 2);
        apply_stimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        wait_until_tick(t + 7);
        check_output("glitch_state", 32'(key_state), 32'b0001);

        // Simultaneous press and release across channels.
        t = tick_no;
        apply_stimulus(4'b0101, 4'b0100, 4'b0000, 4'b0101);
        wait_until_tick(t + 6);
        t = tick_no;
        apply_stimulus(4'b1010, 4'b1010, 4'b0101, 4'b1010);
        wait_until_tick(t + 6);
        check_output("swap_state", 32'(key_state), 32'b1010);

        // Reset after two of three samples: all counts and state are lost,
        // so every held key needs three fresh ticks after reset.
        t = tick_no;
        apply_stimulus(4'b1110, 4'b0000, 4'b0000, 4'b0000);
        wait_until_tick(t + 3);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("midreset_state", 32'(key_state), 32'd0);
        rst_n = 1'b1;
        push_exp(4'b1110, 4'b0000, 4'b0000, 4'b1110, t + 6);
        wait_until_tick(t + 9);
        check_output("post_reset_state", 32'(key_state), 32'b1110);

        // Release everything, then hold key 3 alone for the repeat check.
        t = tick_no;
        apply_stimulus(4'b0000, 4'b0000, 4'b1110, 4'b0000);
        wait_until_tick(t + 6);
`ifdef KEY_REPEAT_EN
        rep_mask = 4'b1000;
`endif
        t = tick_no;
        p = t + STABLE + 1;
        apply_stimulus(4'b1000, 4'b1000, 4'b0000, 4'b1000);
`ifdef KEY_REPEAT_EN
        push_exp(4'b0000, 4'b0000, 4'b1000, 4'b1000, p + 4);
        push_exp(4'b0000, 4'b0000, 4'b1000, 4'b1000, p + 6);
        push_exp(4'b0000, 4'b0000, 4'b1000, 4'b1000, p + 8);
`endif
        wait_until_tick(p + 5);
        apply_stimulus(4'b0000, 4'b0000, 4'b1000, 4'b0000);
        wait_until_tick(p + 13);
        check_output("final_state", 32'(key_state), 32'd0);
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
